// File: rtl/cnn_maxpool_stream.sv
// ---------------------------------------------------------------------------
// cnn_maxpool_stream
//
// Pooling stage that sits behind cnn_top. A start request snapshots the whole
// convolution output frame, then the 2x2 stride-2 max-pooled frame (with
// optional ReLU clamp) is streamed out in row-major order, one beat per
// handshake, tagged with its pooled row/column and a last-beat flag.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-high reset
//   start      : pool the frame on in_image; only looked at while busy=0
//   in_image   : ROWS x COLS signed DW-bit frame (cnn_top output_image)
//   busy       : high from frame acceptance until the final beat handshakes
//   out_data   : pooled value of the current beat
//   out_row    : pooled row index of the current beat
//   out_col    : pooled column index of the current beat
//   out_last   : current beat is the final one (ROWS/2-1, COLS/2-1)
//   out_valid  : beat valid
//   out_ready  : consumer accepts the beat
//   done       : one-cycle pulse after the final handshake
//
// Stream handshake: a beat transfers on every rising edge where out_valid and
// out_ready are both 1. Once out_valid is raised it stays high, and out_data,
// out_row, out_col and out_last stay unchanged, until that edge occurs.
// out_valid never depends combinationally on out_ready.
//
// ROWS and COLS must be even and at least 4 so the index tags have width.
// ---------------------------------------------------------------------------
module cnn_maxpool_stream #(
    parameter int ROWS    = 8,
    parameter int COLS    = 32,
    parameter int DW      = 32,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [DW-1:0]        in_image [0:ROWS-1][0:COLS-1],
    output logic                        busy,
    output logic signed [DW-1:0]        out_data,
    output logic [$clog2(ROWS/2)-1:0]   out_row,
    output logic [$clog2(COLS/2)-1:0]   out_col,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        done
);

    localparam int RW = $clog2(ROWS/2);
    localparam int CW = $clog2(COLS/2);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS/2 - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS/2 - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t state;

    // Frame copy taken at acceptance; deliberately has no reset.
    logic signed [DW-1:0] snapshot [0:ROWS-1][0:COLS-1];

    logic accept;
    logic handshake;

    assign accept    = (state == IDLE) && start;
    assign handshake = out_valid && out_ready;

    // -----------------------------------------------------------------------
    // Index of the beat that will be registered at the next edge. In IDLE it
    // is (0,0); in EMIT it is the successor of the beat currently presented.
    // -----------------------------------------------------------------------
    logic [RW-1:0] nxt_row;
    logic [CW-1:0] nxt_col;
    logic          nxt_last;

    always_comb begin
        nxt_row = '0;
        nxt_col = '0;
        if (state == EMIT) begin
            if (out_col == LAST_COL) begin
                nxt_row = out_row + RW'(1);
                nxt_col = '0;
            end else begin
                nxt_row = out_row;
                nxt_col = out_col + CW'(1);
            end
        end
        nxt_last = (nxt_row == LAST_ROW) && (nxt_col == LAST_COL);
    end

    // -----------------------------------------------------------------------
    // Window fetch. The first beat is computed straight from in_image at the
    // accepting edge because the snapshot is only being written at that same
    // edge; every later beat reads the snapshot.
    // -----------------------------------------------------------------------
    logic [RW:0]          r0, r1;
    logic [CW:0]          c0, c1;
    logic signed [DW-1:0] w00, w01, w10, w11;

    always_comb begin
        r0 = {nxt_row, 1'b0};
        r1 = {nxt_row, 1'b1};
        c0 = {nxt_col, 1'b0};
        c1 = {nxt_col, 1'b1};
        if (state == IDLE) begin
            w00 = in_image[0][0];
            w01 = in_image[0][1];
            w10 = in_image[1][0];
            w11 = in_image[1][1];
        end else begin
            w00 = snapshot[r0][c0];
            w01 = snapshot[r0][c1];
            w10 = snapshot[r1][c0];
            w11 = snapshot[r1][c1];
        end
    end

    // Two-level signed max tree followed by the optional ReLU clamp.
    logic signed [DW-1:0] max_top;
    logic signed [DW-1:0] max_bot;
    logic signed [DW-1:0] max_all;
    logic signed [DW-1:0] pool_val;

    always_comb begin
        max_top  = (w00 > w01) ? w00 : w01;
        max_bot  = (w10 > w11) ? w10 : w11;
        max_all  = (max_top > max_bot) ? max_top : max_bot;
        pool_val = max_all;
        if (RELU_EN && max_all[DW-1]) begin
            pool_val = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Snapshot capture. Kept out of the reset block so the array does not pick
    // up a reset network; the !rst term stops a start seen during reset from
    // counting as an acceptance.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            snapshot <= in_image;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered stream outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= EMIT;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= pool_val;
                        out_row   <= nxt_row;
                        out_col   <= nxt_col;
                        out_last  <= nxt_last;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        if (out_last) begin
                            // Data/tags keep the final beat; only valid drops.
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_data  <= pool_val;
                            out_row   <= nxt_row;
                            out_col   <= nxt_col;
                            out_last  <= nxt_last;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_maxpool_stream.sv
// ---------------------------------------------------------------------------
// Testbench for cnn_maxpool_stream. Two instances share every input: one with
// the ReLU clamp disabled and one with it enabled. Inputs are driven on the
// falling edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_cnn_maxpool_stream;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic signed [31:0] img [0:7][0:31];

    logic               o0_busy, o0_last, o0_valid, o0_done;
    logic signed [31:0] o0_data;
    logic [1:0]         o0_row;
    logic [3:0]         o0_col;

    logic               o1_busy, o1_last, o1_valid, o1_done;
    logic signed [31:0] o1_data;
    logic [1:0]         o1_row;
    logic [3:0]         o1_col;

    cnn_maxpool_stream #(.ROWS(8), .COLS(32), .DW(32), .RELU_EN(1'b0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_image(img),
        .busy(o0_busy), .out_data(o0_data), .out_row(o0_row), .out_col(o0_col),
        .out_last(o0_last), .out_valid(o0_valid), .out_ready(out_ready), .done(o0_done)
    );

    cnn_maxpool_stream #(.ROWS(8), .COLS(32), .DW(32), .RELU_EN(1'b1)) u_relu (
        .clk(clk), .rst(rst), .start(start), .in_image(img),
        .busy(o1_busy), .out_data(o1_data), .out_row(o1_row), .out_col(o1_col),
        .out_last(o1_last), .out_valid(o1_valid), .out_ready(out_ready), .done(o1_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int hold_err = 0;
    int cycles   = 0;
    bit timed_out = 1'b0;

    // Scoreboard: expected values and observed beats.
    logic [31:0] exp_q[$];
    logic [31:0] exp_relu_q[$];
    logic [31:0] obs_d[$];
    logic [31:0] obs_relu[$];
    logic [1:0]  obs_r[$];
    logic [3:0]  obs_c[$];
    logic        obs_l[$];

    // ---------------- stimulus helpers ----------------
    task automatic fill_const(input logic [31:0] v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 32; c++)
                img[r][c] = v;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 32; c++)
                img[r][c] = 32'(32 * r + c);
    endtask

    // Ramp model: the window max is always the bottom-right element.
    function automatic logic [31:0] ramp_pool(input int k);
        int pr, pc;
        pr = k / 16;
        pc = k % 16;
        return 32'(32 * (2 * pr + 1) + 2 * pc + 1);
    endfunction

    task automatic build_ramp_exp();
        exp_q.delete();
        for (int k = 0; k < 64; k++) exp_q.push_back(ramp_pool(k));
    endtask

    task automatic clear_obs();
        obs_d.delete(); obs_relu.delete(); obs_r.delete(); obs_c.delete(); obs_l.delete();
    endtask

    // Called at a falling edge: pulse start across one rising edge.
    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor/driver: from the current falling edge, drive out_ready and log
    // every beat that will handshake at the following rising edge. Stops after
    // the last beat, after max_beats beats, or when the budget expires. Also
    // counts output changes seen while a beat was stalled.
    task automatic run_beats(input bit toggle, input int max_beats, input int budget);
        int          got;
        logic        pv, prdy, pl;
        logic [31:0] pd;
        logic [1:0]  prow;
        logic [3:0]  pcol;
        got = 0; pv = 1'b0; prdy = 1'b0; pl = 1'b0; pd = '0; prow = '0; pcol = '0;
        cycles = 0;
        timed_out = 1'b0;
        forever begin
            out_ready = toggle ? ~out_ready : 1'b1;
            if (pv && !prdy && (o0_valid !== 1'b1 || o0_data !== pd || o0_row !== prow ||
                                o0_col !== pcol || o0_last !== pl))
                hold_err++;
            pv = o0_valid; prdy = out_ready; pd = o0_data; prow = o0_row; pcol = o0_col; pl = o0_last;
            if (o0_valid && out_ready) begin
                obs_d.push_back(o0_data);
                obs_relu.push_back(o1_data);
                obs_r.push_back(o0_row);
                obs_c.push_back(o0_col);
                obs_l.push_back(o0_last);
                got++;
                if (o0_last || got == max_beats) break;
            end
            if (cycles >= budget) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 32; c++)
                    img[r][c] = $urandom;
            @(negedge clk);
        end
        n_checks++;
        if ({o0_valid, o0_busy, o0_done, o0_last, o0_row, o0_col} !== 10'd0)
            $display("FAIL reset_ctrl: got %b required 0", {o0_valid, o0_busy, o0_done, o0_last, o0_row, o0_col});
        else n_pass++;
        n_checks++;
        if (o0_data !== 32'd0 || o1_data !== 32'd0 || o1_valid !== 1'b0 || o1_busy !== 1'b0)
            $display("FAIL reset_data: got %h/%h valid1=%b busy1=%b required 0", o0_data, o1_data, o1_valid, o1_busy);
        else n_pass++;
        start = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o0_valid, o0_busy, o0_done, o0_last, o0_row, o0_col} !== 10'd0 || o0_data !== 32'd0)
            $display("FAIL reset_release: ctrl %b data %h required 0",
                     {o0_valid, o0_busy, o0_done, o0_last, o0_row, o0_col}, o0_data);
        else n_pass++;
    endtask

    task automatic test_ramp();
        fill_ramp();
        build_ramp_exp();
        out_ready = 1'b1;
        kick();
        n_checks++;
        if (o0_valid !== 1'b1 || o0_busy !== 1'b1 || o0_data !== 32'd33)
            $display("FAIL ramp_latency: valid %b busy %b data %0d required 1 1 33", o0_valid, o0_busy, o0_data);
        else n_pass++;
        clear_obs();
        run_beats(1'b0, 64, 200);
        n_checks++;
        if (obs_d.size() != 64 || timed_out)
            $display("FAIL ramp_count: got %0d beats (timeout %b) required 64", obs_d.size(), timed_out);
        else n_pass++;
        n_checks++;
        if (obs_d.size() < 64 || obs_d[0] !== 32'd33 || obs_d[1] !== 32'd35 || obs_c[1] !== 4'd1)
            $display("FAIL ramp_first: beats %0d beat1/2 not 33,35 at col 0,1", obs_d.size());
        else n_pass++;
        n_checks++;
        if (obs_d.size() < 64 || obs_d[63] !== 32'd255 || obs_r[63] !== 2'd3 || obs_c[63] !== 4'd15 ||
            obs_l[63] !== 1'b1 || obs_relu[63] !== 32'd255)
            $display("FAIL ramp_last: beat 64 not (3,15)=255 last=1");
        else n_pass++;
        n_checks++;
        if (cycles != 63)
            $display("FAIL ramp_throughput: last beat at cycle %0d required 63", cycles);
        else n_pass++;
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (k >= obs_d.size())
                $display("FAIL ramp_beat%0d: missing required %0d", k, exp_q[k]);
            else if (obs_d[k] !== exp_q[k] || obs_r[k] !== 2'(k / 16) || obs_c[k] !== 4'(k % 16) ||
                     obs_l[k] !== (k == 63))
                $display("FAIL ramp_beat%0d: got %0d (%0d,%0d,%b) required %0d (%0d,%0d,%b)",
                         k, obs_d[k], obs_r[k], obs_c[k], obs_l[k], exp_q[k], k / 16, k % 16, k == 63);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (o0_done !== 1'b1 || o0_valid !== 1'b0 || o0_busy !== 1'b0)
            $display("FAIL ramp_done: done %b valid %b busy %b required 1 0 0", o0_done, o0_valid, o0_busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (o0_done !== 1'b0 || o0_valid !== 1'b0)
            $display("FAIL ramp_done_pulse: done %b valid %b required 0 0", o0_done, o0_valid);
        else n_pass++;
    endtask

    task automatic test_signed_relu();
        // All -5: plain instance passes -5 through, ReLU instance clamps to 0.
        fill_const(32'hFFFF_FFFB);
        out_ready = 1'b1;
        kick();
        clear_obs();
        run_beats(1'b0, 64, 200);
        n_checks++;
        if (obs_d.size() != 64)
            $display("FAIL neg5_count: got %0d beats required 64", obs_d.size());
        else n_pass++;
        for (int k = 0; k < obs_d.size(); k++) begin
            n_checks++;
            if (obs_d[k] !== 32'hFFFF_FFFB || obs_relu[k] !== 32'd0)
                $display("FAIL neg5_beat%0d: got %h/%h required fffffffb/00000000", k, obs_d[k], obs_relu[k]);
            else n_pass++;
        end
        repeat (2) @(negedge clk);

        // Planted windows over a most-negative background.
        fill_const(32'h8000_0000);
        img[0][0] = 32'h7FFF_FFFF; img[0][1] = 32'h8000_0000; img[1][0] = 32'd0;  img[1][1] = 32'hFFFF_FFFF;
        img[0][2] = 32'd1;         img[0][3] = 32'd2;         img[1][2] = 32'd9;  img[1][3] = 32'd3;
        img[0][4] = 32'd50;        img[0][5] = -32'sd1;       img[1][4] = -32'sd2; img[1][5] = -32'sd3;
        img[2][4] = -32'sd7;       img[2][5] = -32'sd3;       img[3][4] = -32'sd100; img[3][5] = 32'h8000_0000;
        exp_q.delete();
        exp_relu_q.delete();
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(32'h8000_0000);
            exp_relu_q.push_back(32'd0);
        end
        exp_q[0] = 32'h7FFF_FFFF; exp_relu_q[0] = 32'h7FFF_FFFF;
        exp_q[1] = 32'd9;         exp_relu_q[1] = 32'd9;
        exp_q[2] = 32'd50;        exp_relu_q[2] = 32'd50;
        exp_q[18] = 32'hFFFF_FFFD;
        kick();
        clear_obs();
        run_beats(1'b0, 64, 200);
        n_checks++;
        if (obs_d.size() != 64)
            $display("FAIL window_count: got %0d beats required 64", obs_d.size());
        else n_pass++;
        for (int k = 0; k < obs_d.size(); k++) begin
            n_checks++;
            if (obs_d[k] !== exp_q[k] || obs_relu[k] !== exp_relu_q[k])
                $display("FAIL window_beat%0d: got %h/%h required %h/%h", k, obs_d[k], obs_relu[k], exp_q[k], exp_relu_q[k]);
            else n_pass++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        fill_ramp();
        build_ramp_exp();
        out_ready = 1'b0;
        kick();
        clear_obs();
        hold_err = 0;
        run_beats(1'b1, 64, 400);
        n_checks++;
        if (obs_d.size() != 64 || timed_out)
            $display("FAIL bp_count: got %0d beats (timeout %b) required 64", obs_d.size(), timed_out);
        else n_pass++;
        n_checks++;
        if (hold_err != 0)
            $display("FAIL bp_hold: %0d stalled cycles changed outputs, required 0", hold_err);
        else n_pass++;
        n_checks++;
        if (cycles != 126)
            $display("FAIL bp_cycles: last beat at cycle %0d required 126", cycles);
        else n_pass++;
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (k >= obs_d.size())
                $display("FAIL bp_beat%0d: missing required %0d", k, exp_q[k]);
            else if (obs_d[k] !== exp_q[k] || obs_r[k] !== 2'(k / 16) || obs_c[k] !== 4'(k % 16) ||
                     obs_l[k] !== (k == 63))
                $display("FAIL bp_beat%0d: got %0d (%0d,%0d,%b) required %0d", k, obs_d[k], obs_r[k], obs_c[k], obs_l[k], exp_q[k]);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (o0_done !== 1'b1 || o0_valid !== 1'b0)
            $display("FAIL bp_done: done %b valid %b required 1 0", o0_done, o0_valid);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        fill_ramp();
        out_ready = 1'b1;
        start = 1'b1;              // held for the whole frame and beyond
        @(negedge clk);
        clear_obs();
        run_beats(1'b0, 64, 200);
        n_checks++;
        if (obs_d.size() != 64 || obs_d[10] !== 32'd53 || obs_d[63] !== 32'd255)
            $display("FAIL b2b_no_restart: got %0d beats, required 64 ending at 255", obs_d.size());
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (o0_done !== 1'b1 || o0_valid !== 1'b0)
            $display("FAIL b2b_done: done %b valid %b required 1 0", o0_done, o0_valid);
        else n_pass++;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (o0_valid !== 1'b1 || o0_data !== 32'd33 || o0_row !== 2'd0 || o0_col !== 4'd0 || o0_done !== 1'b0)
            $display("FAIL b2b_retrigger: valid %b data %0d (%0d,%0d) done %b required 1 33 (0,0) 0",
                     o0_valid, o0_data, o0_row, o0_col, o0_done);
        else n_pass++;
        clear_obs();
        run_beats(1'b0, 64, 200);
        n_checks++;
        if (obs_d.size() != 64)
            $display("FAIL b2b_second_count: got %0d beats required 64", obs_d.size());
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_isolation();
        fill_ramp();
        build_ramp_exp();
        out_ready = 1'b1;
        kick();
        clear_obs();
        run_beats(1'b0, 10, 100);
        // Start while busy, and wipe the input frame mid-flight.
        start = 1'b1;
        fill_const(32'd0);
        @(negedge clk);
        start = 1'b0;
        run_beats(1'b0, 64, 200);
        n_checks++;
        if (obs_d.size() != 64)
            $display("FAIL iso_count: got %0d beats required 64", obs_d.size());
        else n_pass++;
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (k >= obs_d.size())
                $display("FAIL iso_beat%0d: missing required %0d", k, exp_q[k]);
            else if (obs_d[k] !== exp_q[k] || obs_r[k] !== 2'(k / 16) || obs_c[k] !== 4'(k % 16))
                $display("FAIL iso_beat%0d: got %0d (%0d,%0d) required %0d", k, obs_d[k], obs_r[k], obs_c[k], exp_q[k]);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (o0_done !== 1'b1)
            $display("FAIL iso_done: done %b required 1", o0_done);
        else n_pass++;
        @(negedge clk);
        kick();
        clear_obs();
        run_beats(1'b0, 64, 200);
        n_checks++;
        if (obs_d.size() != 64)
            $display("FAIL zero_count: got %0d beats required 64", obs_d.size());
        else n_pass++;
        for (int k = 0; k < obs_d.size(); k++) begin
            n_checks++;
            if (obs_d[k] !== 32'd0)
                $display("FAIL zero_beat%0d: got %0d required 0", k, obs_d[k]);
            else n_pass++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        fill_ramp();
        out_ready = 1'b1;
        kick();
        clear_obs();
        run_beats(1'b0, 20, 100);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({o0_valid, o0_busy, o0_done, o0_last, o0_row, o0_col} !== 10'd0 || o0_data !== 32'd0)
            $display("FAIL midrst_clear: ctrl %b data %h required 0",
                     {o0_valid, o0_busy, o0_done, o0_last, o0_row, o0_col}, o0_data);
        else n_pass++;
        n_checks++;
        if (obs_d.size() != 20 || obs_d[19] !== ramp_pool(19))
            $display("FAIL midrst_pre: got %0d beats required 20 ending at %0d", obs_d.size(), ramp_pool(19));
        else n_pass++;
        saw_done = 1'b0;
        @(negedge clk);
        if (o0_done) saw_done = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o0_done || o0_valid) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done)
            $display("FAIL midrst_no_done: done/valid seen after reset, required none");
        else n_pass++;
        kick();
        n_checks++;
        if (o0_valid !== 1'b1 || o0_data !== 32'd33 || o0_row !== 2'd0 || o0_col !== 4'd0)
            $display("FAIL midrst_restart: valid %b data %0d (%0d,%0d) required 1 33 (0,0)", o0_valid, o0_data, o0_row, o0_col);
        else n_pass++;
        clear_obs();
        run_beats(1'b0, 64, 200);
        n_checks++;
        if (obs_d.size() != 64 || obs_d[63] !== 32'd255)
            $display("FAIL midrst_frame: got %0d beats required 64 ending at 255", obs_d.size());
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        fill_const(32'd0);
        #1;
        test_reset();
        test_ramp();
        test_signed_relu();
        test_backpressure();
        test_back_to_back();
        test_isolation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/cnn_maxpool_stream.md
# cnn_maxpool_stream

Downstream stage of `cnn_top`. On a `start` pulse it snapshots the full convolution output frame (ROWS×COLS signed words). It computes 2×2 stride-2 max-pooling, with optional ReLU. The pooled frame is streamed out in row-major order on a valid/ready interface, with row/column tags and a last-beat flag.

## Interface
Parameters:
- `ROWS`, 8, input frame rows; must be even.
- `COLS`, 32, input frame columns; must be even.
- `DW`, 32, word width; signed two's complement.
- `RELU_EN`, 1, when 1, negative pooled results are clamped to 0.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request to pool the current frame; sampled only when `busy`=0.
- `in_image`  in  DW × [0:ROWS-1][0:COLS-1]  frame from `cnn_top` `output_image`.
- `busy`  out  1  high from frame acceptance until the final beat handshakes.
- `out_data`  out  DW  pooled value.
- `out_row`  out  $clog2(ROWS/2)  pooled row index of the current beat.
- `out_col`  out  $clog2(COLS/2)  pooled column index of the current beat.
- `out_last`  out  1  high on the final beat, (ROWS/2-1, COLS/2-1).
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  consumer accepts the beat.
- `done`  out  1  one-cycle pulse after the final handshake.

## Operation
- The FSM has two states, IDLE and EMIT.
- IDLE → EMIT: at a clock edge where `start`=1 and `busy`=0.
  - `in_image` is copied into an internal snapshot register array.
  - The pooled index is set to (0,0).
  - `out_data` is loaded with the pooled value for (0,0), computed directly from `in_image` at that edge.
  - `out_valid`=1 and `busy`=1.
- The snapshot is not reset and is written only on acceptance. Later changes to `in_image` never affect the frame in flight.
- Pooled value at (pr,pc) = signed max of snapshot[2pr][2pc], [2pr][2pc+1], [2pr+1][2pc] and [2pr+1][2pc+1]. If `RELU_EN`=1 and the result is negative, the output is 0.
- A handshake is an edge with `out_valid`=1 and `out_ready`=1.
  - On a non-final handshake, the index advances (column first, wrapping to the next row). The next pooled value, row, col and last flag are registered at the same edge, giving no bubble.
  - On the final handshake (`out_last`=1): `out_valid`←0, `busy`←0, `done`←1, and the FSM goes to IDLE.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_row`, `out_col` and `out_last` hold stable.
- `start` is ignored while `busy`=1; no queueing.
- `done` is high for exactly one cycle, then returns to 0.

## Timing
- Reset values: `busy`=0, `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0, `done`=0. The FSM resets to IDLE.
- `rst` asserted mid-frame clears all outputs immediately, because the reset is asynchronous. The frame is abandoned and no `done` is issued.
- Latency: first beat valid in the cycle right after the accepting edge, i.e. 1 cycle.
- Throughput: 1 beat/cycle while `out_ready` is held high. A frame takes (ROWS/2)·(COLS/2) beats, 64 at the defaults.
- With `out_ready` held high and start accepted at edge E0:
  - Beats are handshaken at E1 through E64.
  - `done` is high during the cycle after E64.
  - A new `start` can be accepted at E65. `start` held high continuously re-triggers there.
- Arithmetic uses signed DW-bit compares with no widening.
- Combinational depth per beat: a 4-input max tree plus the ReLU mux, feeding a registered output.

## Test plan
- Reset with `rst`=1 and random inputs → all outputs 0, `busy`=0. Releasing `rst` with `start`=0 → outputs stay 0.
- Ramp frame `in_image[r][c]`=32r+c, `RELU_EN`=0, `out_ready`=1, start pulse →
  - Beat 1: (0,0)=33. Beat 2: (0,1)=35. Beat 64: (3,15)=255 with `out_last`=1.
  - `done` is a one-cycle pulse after beat 64. Exactly 64 handshakes occur.
- Signed and ReLU checks:
  - Frame all −5, `RELU_EN`=1 → all 64 outputs 0. With `RELU_EN`=0 → all −5.
  - Window {0x7FFFFFFF, 0x80000000, 0, −1} → 0x7FFFFFFF.
- Backpressure with `out_ready` toggled every cycle on the ramp frame →
  - Outputs are stable whenever valid=1 and ready=0.
  - The sequence is identical to the ramp case, with 64 handshakes over ~128 cycles.
- Start while busy, and snapshot isolation:
  - Pulse `start` at beat 10 and overwrite `in_image` with zeros → no restart, and the remaining beats still match the ramp frame.
  - A new start after `done` pools the zero frame.
- Reset mid-frame: assert `rst` at beat 20 → outputs 0 immediately and no `done`. A subsequent start restarts at (0,0)=33 on the ramp frame.
